// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Store queue between the EX/MEM pipeline register and the single-ported
//   data memory. Stores are queued and drained into DM one per cycle whenever
//   no load owns the port. Loads always win the port. A load that matches a
//   pending store gets the youngest matching buffered word forwarded.
//
// Optional build macro:
//   STB_COALESCE_EN - a store to the same word as the youngest pending entry
//                     overwrites that entry's data instead of allocating.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_st_valid/addr/data          store request from MEM stage
//   o_st_ready                    buffer not full
//   i_ld_valid/addr               load request from MEM stage
//   o_ld_data, o_ld_hit           load result and "came from buffer" flag
//   o_dm_MemRead/MemWrite         DM strobes
//   o_dm_addr, o_dm_wdata         DM address / write data
//   i_dm_rdata                    DM read data (combinational)
//   o_count, o_empty              occupancy
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_st_valid,
    input  logic [31:0]      i_st_addr,
    input  logic [31:0]      i_st_data,
    output logic             o_st_ready,
    input  logic             i_ld_valid,
    input  logic [31:0]      i_ld_addr,
    output logic [31:0]      o_ld_data,
    output logic             o_ld_hit,
    output logic             o_dm_MemRead,
    output logic             o_dm_MemWrite,
    output logic [31:0]      o_dm_addr,
    output logic [31:0]      o_dm_wdata,
    input  logic [31:0]      i_dm_rdata,
    output logic [PTR_W:0]   o_count,
    output logic             o_empty
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    // Entry storage: word address (bits [31:2]) and data.
    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_drain;
    logic             w_alloc;
    logic             w_coal;
    logic [PTR_W-1:0] w_last;
    logic [DEPTH-1:0] w_match;
    logic             w_hit;
    logic [31:0]      w_fwd;
    logic             w_unused;

    // Byte offset bits are irrelevant for full-word accesses.
    assign w_unused = ^{i_st_addr[1:0], i_ld_addr[1:0]};

    assign o_st_ready = (r_count != C_FULL);
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);

    assign w_push  = i_st_valid && o_st_ready;
    assign w_drain = !i_ld_valid && (r_count != '0);
    assign w_last  = r_tail - 1'b1;

`ifdef STB_COALESCE_EN
    // Merge into the youngest entry unless that entry is leaving this cycle
    // (it is then also the head); in that case a fresh entry is allocated.
    assign w_coal = w_push && (r_count != '0)
                 && (r_addr[w_last] == i_st_addr[31:2])
                 && !(w_drain && (w_last == r_head));
`else
    assign w_coal = 1'b0;
`endif

    assign w_alloc = w_push && !w_coal;

    // Per-entry match: an entry is live when its distance from head is
    // below the occupancy count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] w_age;
            assign w_age       = PTR_W'(gi) - r_head;
            assign w_match[gi] = ({1'b0, w_age} < r_count)
                              && (r_addr[gi] == i_ld_addr[31:2]);
        end
    endgenerate

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[r_head + PTR_W'(i)]) begin
                w_hit = 1'b1;
                w_fwd = r_data[r_head + PTR_W'(i)];
            end
        end
    end

    assign o_ld_hit  = w_hit;
    assign o_ld_data = w_hit ? w_fwd : i_dm_rdata;

    // DM port arbitration: load > drain > idle.
    always_comb begin
        o_dm_MemRead  = 1'b0;
        o_dm_MemWrite = 1'b0;
        o_dm_addr     = '0;
        o_dm_wdata    = '0;
        if (i_ld_valid) begin
            o_dm_MemRead = 1'b1;
            o_dm_addr    = i_ld_addr;
        end else if (w_drain) begin
            o_dm_MemWrite = 1'b1;
            o_dm_addr     = {r_addr[r_head], 2'b00};
            o_dm_wdata    = r_data[r_head];
        end
    end

    // Entry arrays carry no reset; validity is implied by head/count.
    always_ff @(posedge i_clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= i_st_addr[31:2];
            r_data[r_tail] <= i_st_data;
        end
        if (w_coal) begin
            r_data[w_last] <= i_st_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) r_tail <= r_tail + 1'b1;
            if (w_drain) r_head <= r_head + 1'b1;
            case ({w_alloc, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer. Stimulus pushes expected DM writes and
//   expected load results into queues; a monitor on the falling edge pops
//   and compares whenever the DUT writes DM or a checked load is presented.
//   A small DM model returns 0xBAD00000|addr for never-written words.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        dm_re;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [2:0]  count;
    logic        empty;

    logic        ld_chk;
    int          tests;
    int          fails;
    logic [63:0] wr_q[$];
    logic [32:0] ld_q[$];
    logic [31:0] mem [64];

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_st_valid   (st_valid),
        .i_st_addr    (st_addr),
        .i_st_data    (st_data),
        .o_st_ready   (st_ready),
        .i_ld_valid   (ld_valid),
        .i_ld_addr    (ld_addr),
        .o_ld_data    (ld_data),
        .o_ld_hit     (ld_hit),
        .o_dm_MemRead (dm_re),
        .o_dm_MemWrite(dm_we),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .i_dm_rdata   (dm_rdata),
        .o_count      (count),
        .o_empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DM model: combinational read, write at rising edge.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hBAD0_0000 | (i << 2);
    end
    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        cyc(1);
        st_valid = 1'b0;
    endtask

    // Monitor: compares DM writes and checked loads against the scoreboard.
    always @(negedge clk) begin
        logic [63:0] ew;
        logic [32:0] el;
        if (!rst && dm_we) begin
            if (wr_q.size() == 0) begin
                chk("dm_write_unexpected", {dm_addr, dm_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ew = wr_q.pop_front();
                chk("dm_write", {dm_addr, dm_wdata}, ew);
            end
        end
        if (ld_chk) begin
            if (ld_q.size() == 0) begin
                chk("load_no_expect", {31'd0, ld_hit, ld_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                el = ld_q.pop_front();
                chk("load_result", {31'd0, ld_hit, ld_data}, {31'd0, el});
            end
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_chk   = 1'b0;
        cyc(2);
        rst = 1'b0;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(st_ready), 64'd1);
        chk("rst_memwrite", 64'(dm_we), 64'd0);
        chk("rst_memread", 64'(dm_re), 64'd0);

        // Single store then DM readback
        wr_q.push_back({32'h10, 32'hDEAD_BEEF});
        push(32'h10, 32'hDEAD_BEEF);
        chk("single_count1", 64'(count), 64'd1);
        chk("single_memwrite", 64'(dm_we), 64'd1);
        cyc(1);
        chk("single_count0", 64'(count), 64'd0);
        ld_valid = 1'b1; ld_addr = 32'h10; ld_chk = 1'b1;
        ld_q.push_back({1'b0, 32'hDEAD_BEEF});
        cyc(1);
        ld_chk = 1'b0;

        // Fill with drain blocked by loads, then backpressure
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back({32'(i * 4), 32'h1000_0000 + 32'(i)});
            push(32'(i * 4), 32'h1000_0000 + 32'(i));
        end
        chk("full_ready", 64'(st_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        push(32'h40, 32'h5555_5555);
        chk("drop_count", 64'(count), 64'd4);
        ld_addr = 32'h8; ld_chk = 1'b1;
        ld_q.push_back({1'b1, 32'h1000_0002});
        cyc(1);
        ld_chk = 1'b0;
        ld_valid = 1'b0;
        cyc(4);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_ready", 64'(st_ready), 64'd1);

        // Forwarding picks the youngest match
        ld_valid = 1'b1; ld_addr = 32'h0;
`ifdef STB_COALESCE_EN
        wr_q.push_back({32'h20, 32'h2222_2222});
`else
        wr_q.push_back({32'h20, 32'h1111_1111});
        wr_q.push_back({32'h20, 32'h2222_2222});
`endif
        push(32'h20, 32'h1111_1111);
        push(32'h20, 32'h2222_2222);
        ld_addr = 32'h20; ld_chk = 1'b1;
        ld_q.push_back({1'b1, 32'h2222_2222});
        cyc(1);
        ld_addr = 32'h24;
        ld_q.push_back({1'b0, 32'hBAD0_0024});
        cyc(1);
        // Store in the same cycle as a load to that word is not visible yet
        ld_addr = 32'h50;
        ld_q.push_back({1'b0, 32'hBAD0_0050});
        wr_q.push_back({32'h50, 32'h5050_5050});
        push(32'h50, 32'h5050_5050);
        ld_q.push_back({1'b1, 32'h5050_5050});
        cyc(1);
        ld_chk = 1'b0;
        ld_valid = 1'b0;
        cyc(3);
        chk("fwd_empty", 64'(empty), 64'd1);

        // Coalescing (or not) of back-to-back same-word stores
        ld_valid = 1'b1; ld_addr = 32'h0;
`ifdef STB_COALESCE_EN
        wr_q.push_back({32'h30, 32'hB});
`else
        wr_q.push_back({32'h30, 32'hA});
        wr_q.push_back({32'h30, 32'hB});
`endif
        push(32'h30, 32'hA);
        push(32'h30, 32'hB);
`ifdef STB_COALESCE_EN
        chk("coal_count", 64'(count), 64'd1);
`else
        chk("coal_count", 64'(count), 64'd2);
`endif
        ld_valid = 1'b0;
        cyc(3);
        chk("coal_empty", 64'(empty), 64'd1);

        // Reset mid-operation discards pending stores
        ld_valid = 1'b1; ld_addr = 32'h0;
        push(32'h60, 32'h6);
        push(32'h64, 32'h7);
        push(32'h68, 32'h8);
        chk("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        ld_valid = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        cyc(4);

        chk("writes_outstanding", 64'(wr_q.size()), 64'd0);
        chk("loads_outstanding", 64'(ld_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the EX/MEM pipeline register and the data memory (DM) in the pipeline CPU.
- Queues store words from the MEM stage and drains them into DM one per cycle when the DM port is free.
- Loads have priority on the single DM port.
- Loads that hit a pending store get the buffered data forwarded, so the pipeline never stalls on store-then-load.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_st_valid  in  1  MEM stage presents a store this cycle.
- i_st_addr  in  32  store byte address; word-aligned (bits [1:0] ignored).
- i_st_data  in  32  store data word.
- o_st_ready  out  1  buffer can accept a store this cycle.
- i_ld_valid  in  1  MEM stage presents a load this cycle.
- i_ld_addr  in  32  load byte address; word-aligned.
- o_ld_data  out  32  load result: forwarded or from DM.
- o_ld_hit  out  1  load was satisfied from the buffer.
- o_dm_MemRead  out  1  DM read strobe.
- o_dm_MemWrite  out  1  DM write strobe.
- o_dm_addr  out  32  DM address.
- o_dm_wdata  out  32  DM write data.
- i_dm_rdata  in  32  DM read data (combinational from DM).
- o_count  out  PTR_W+1  number of valid entries.
- o_empty  out  1  o_count==0.

Behaviour:
- Reset (i_rst=1 at rising edge):
  - head, tail and count cleared; all entries invalid; pending stores discarded, including mid-drain.
  - After reset: o_count=0, o_empty=1, o_st_ready=1, o_dm_MemWrite=0.
- Storage: circular FIFO. Push writes entry[tail] and increments tail; pop increments head. Pointers wrap modulo DEPTH.
- o_st_ready = (count != DEPTH).
  - A pop in the same cycle does not make a full buffer ready.
  - i_st_valid while !o_st_ready is ignored; the upstream stage must stall.
- Push: on rising edge when i_st_valid && o_st_ready. An entry pushed in cycle N is drainable from cycle N+1 at the earliest.
- DM port arbitration (combinational):
  - Load (i_ld_valid=1): o_dm_MemRead=1, o_dm_MemWrite=0, o_dm_addr=i_ld_addr, o_dm_wdata=0. No drain this cycle.
  - Drain (!i_ld_valid && count!=0): o_dm_MemRead=0, o_dm_MemWrite=1, o_dm_addr=entry[head].addr, o_dm_wdata=entry[head].data. Pop occurs at the same rising edge on which DM captures the write.
  - Idle: MemRead=0, MemWrite=0, addr=0, wdata=0.
- Load forwarding:
  - Compare i_ld_addr[31:2] against all valid entries' addr[31:2]. If any match, o_ld_hit=1 and o_ld_data = data of the youngest matching entry (closest to tail).
  - Otherwise o_ld_hit=0 and o_ld_data=i_dm_rdata.
  - A store pushed in the same cycle as a load is not visible to that load.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full-word accesses only; no byte or halfword merging.

Optional Feature:
- Macro STB_COALESCE_EN.
- Defined: a pushed store whose addr[31:2] equals the youngest valid entry (tail-1) overwrites that entry's data in place. Tail and count do not change, and o_st_ready stays as computed.
  - Exception: if that entry is also head and is being drained this cycle, allocate normally instead.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset then idle: o_count=0, o_empty=1, o_st_ready=1, o_dm_MemWrite=0, o_dm_MemRead=0.
- Single store: push addr 0x10 / data 0xDEADBEEF, no loads. Next cycle o_dm_MemWrite=1, addr 0x10, wdata 0xDEADBEEF. Following cycle count=0, and a DM load from 0x10 returns 0xDEADBEEF.
- Fill and backpressure, DEPTH=4, loads held high to block draining:
  - Push 4 stores to 0x0/0x4/0x8/0xC: o_st_ready=0 and count=4.
  - A 5th i_st_valid is dropped.
  - Release loads: four consecutive DM writes in push order, then o_empty=1.
- Forwarding youngest: push 0x20=0x11111111, then 0x20=0x22222222, with loads blocking drain. Load 0x20 gives o_ld_hit=1, o_ld_data=0x22222222. Load 0x24 gives o_ld_hit=0, o_ld_data=i_dm_rdata.
- Reset mid-operation: 3 pending entries, assert i_rst one cycle. Count=0 and no DM write occurs afterward.
- STB_COALESCE_EN:
  - Pushes 0x30=0xA then 0x30=0xB with drain blocked give count=1; drained data is 0xB.
  - With the macro undefined, count=2 and DM receives 0xA then 0xB.
